// File: rtl/s_u_rdiv_seq.sv
// Sequential unsigned restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Optional macro S_U_RDIV_SKIP_EN skips the N leading zero steps when the dividend upper half is zero.
module s_u_rdiv_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int CW = $clog2(2 * N) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg, state_next;
  logic [N-1:0]   r_reg;
  logic [2*N-1:0] q_reg;
  logic [N-1:0]   d_reg;
  logic [CW-1:0]  cnt_reg;

  logic           accept;
  logic           last_step;
  logic [N:0]     shifted;
  logic [N:0]     trial;
  logic [N-1:0]   r_step;
  logic [2*N-1:0] q_step;

  assign accept    = in_valid && (state_reg == IDLE);
  assign last_step = (cnt_reg == CW'(2 * N - 1));

  // One restoring step; a set sign bit on the trial difference means restore.
  // The restored value always fits in N bits: shifted[N]=1 would make the trial non-negative.
  always_comb begin
    shifted = {r_reg, q_reg[2*N-1]};
    trial   = shifted - {1'b0, d_reg};
    if (!trial[N]) begin
      r_step = trial[N-1:0];
      q_step = {q_reg[2*N-2:0], 1'b1};
    end else begin
      r_step = shifted[N-1:0];
      q_step = {q_reg[2*N-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = (divisor == '0) ? DONE : RUN;
      RUN:  if (last_step) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      cnt_reg     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        if (divisor == '0) begin
          quotient    <= '1;
          remainder   <= dividend[N-1:0];
          div_by_zero <= 1'b1;
        end else begin
          div_by_zero <= 1'b0;
          r_reg       <= '0;
          d_reg       <= divisor;
`ifdef S_U_RDIV_SKIP_EN
          if (dividend[2*N-1:N] == '0) begin
            q_reg   <= {dividend[N-1:0], {N{1'b0}}};
            cnt_reg <= CW'(N);
          end else begin
            q_reg   <= dividend;
            cnt_reg <= '0;
          end
`else
          q_reg   <= dividend;
          cnt_reg <= '0;
`endif
        end
      end else if (state_reg == RUN) begin
        r_reg   <= r_step;
        q_reg   <= q_step;
        cnt_reg <= cnt_reg + CW'(1);
        if (last_step) begin
          quotient  <= q_step;
          remainder <= r_step;
        end
      end
    end
  end

endmodule
